// File: rtl/dip_lookup_arbiter.sv
// Round-robin front end sharing one fixed-latency DIP prefix match tree, with a credit-protected result FIFO.
// Optional issue/stall counters are enabled by defining DIP_ARB_STATS_EN.
module dip_lookup_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IP_WIDTH  = 32,
  parameter int RES_WIDTH = 32,
  parameter int LAT       = 6,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*IP_WIDTH-1:0]  req_ip,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [IP_WIDTH:0]            tree_in,
  input  logic [RES_WIDTH-1:0]         tree_out,
  output logic                         resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [RES_WIDTH-1:0]         resp_rule_set,
  input  logic                         resp_ready,
  output logic                         busy
`ifdef DIP_ARB_STATS_EN
  ,
  output logic [15:0]                  stat_lookups,
  output logic [15:0]                  stat_stall
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [IDW:0]   NREQ_C  = (IDW + 1)'(NUM_REQ);
  localparam logic [PW-1:0]  LASTP_C = PW'(DEPTH - 1);

  logic [IDW-1:0]      rr_q;
  logic [CW-1:0]       used_q, used_d;
  logic [IP_WIDTH:0]   treeIn_q;
  logic [IDW-1:0]      issueId_q;
  logic                issueOk, transfer, found;
  logic [IDW-1:0]      grantIdx, idxL;
  logic [IDW:0]        idxSum;
  logic [IP_WIDTH-1:0] grantIp;

  logic [LAT-1:0]      tagValid_q;
  logic [IDW-1:0]      tagId_q [LAT];

  logic [RES_WIDTH-1:0] memRule_q [DEPTH];
  logic [IDW-1:0]       memId_q [DEPTH];
  logic [PW-1:0]        wrPtr_q, rdPtr_q;
  logic [CW-1:0]        count_q;
  logic                 pushEn, popEn;

  // Requests are held off while reset is high so every output reads 0 during reset.
  always_comb begin
    req_ready = '0;
    transfer  = 1'b0;
    found     = 1'b0;
    grantIdx  = '0;
    idxSum    = '0;
    idxL      = '0;
    grantIp   = '0;
    issueOk   = !reset && (used_q < DEPTH_C);
    for (int k = 0; k < NUM_REQ; k++) begin
      idxSum = {1'b0, rr_q} + (IDW + 1)'(k);
      if (idxSum >= NREQ_C) idxSum = idxSum - NREQ_C;
      idxL = idxSum[IDW-1:0];
      if (!found && req_valid[idxL]) begin
        found    = 1'b1;
        grantIdx = idxL;
      end
    end
    if (found && issueOk) begin
      req_ready[grantIdx] = 1'b1;
      transfer            = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == grantIdx) grantIp = req_ip[(NUM_REQ-1-i)*IP_WIDTH +: IP_WIDTH];
    end
  end

  assign pushEn     = tagValid_q[LAT-1];
  assign resp_valid = (count_q != '0);
  assign popEn      = resp_valid && resp_ready;

  always_comb begin
    used_d = used_q;
    if (transfer && !popEn)      used_d = used_q + 1'b1;
    else if (!transfer && popEn) used_d = used_q - 1'b1;
  end

  // Issue register and tag pipeline advance together so the tag lines up with tree_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q       <= '0;
      used_q     <= '0;
      treeIn_q   <= '0;
      issueId_q  <= '0;
      tagValid_q <= '0;
      for (int j = 0; j < LAT; j++) tagId_q[j] <= '0;
    end else begin
      if (transfer) rr_q <= (grantIdx == IDW'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
      used_q        <= used_d;
      treeIn_q      <= transfer ? {1'b1, grantIp} : '0;
      issueId_q     <= transfer ? grantIdx : '0;
      tagValid_q[0] <= treeIn_q[IP_WIDTH];
      tagId_q[0]    <= issueId_q;
      for (int j = 1; j < LAT; j++) begin
        tagValid_q[j] <= tagValid_q[j-1];
        tagId_q[j]    <= tagId_q[j-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) wrPtr_q <= (wrPtr_q == LASTP_C) ? '0 : wrPtr_q + 1'b1;
      if (popEn)  rdPtr_q <= (rdPtr_q == LASTP_C) ? '0 : rdPtr_q + 1'b1;
      if (pushEn && !popEn)      count_q <= count_q + 1'b1;
      else if (!pushEn && popEn) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      memRule_q[wrPtr_q] <= tree_out;
      memId_q[wrPtr_q]   <= tagId_q[LAT-1];
    end
  end

  assign resp_id       = resp_valid ? memId_q[rdPtr_q] : '0;
  assign resp_rule_set = resp_valid ? memRule_q[rdPtr_q] : '0;
  assign tree_in       = treeIn_q;
  assign busy          = (used_q != '0);

  overflowCheck: assert property (@(posedge clk) disable iff (reset) !(pushEn && (count_q == DEPTH_C)));

`ifdef DIP_ARB_STATS_EN
  logic [15:0] statLookups_q, statStall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      statLookups_q <= '0;
      statStall_q   <= '0;
    end else begin
      if (transfer) statLookups_q <= statLookups_q + 16'd1;
      if ((|req_valid) && !transfer && (statStall_q != 16'hFFFF)) statStall_q <= statStall_q + 16'd1;
    end
  end

  assign stat_lookups = statLookups_q;
  assign stat_stall   = statStall_q;
`endif

endmodule

// File: tb/tb_dip_lookup_arbiter.sv
// Directed bench for dip_lookup_arbiter with a behavioural fixed-latency match tree.
// Covers reset values, round-robin order, latency, no-match, credit back-pressure and mid-flight reset.
module tb_dip_lookup_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int IP_WIDTH  = 32;
  localparam int RES_WIDTH = 32;
  localparam int LAT       = 6;
  localparam int DEPTH     = 8;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*IP_WIDTH-1:0] req_ip;
  logic [NUM_REQ-1:0]          req_ready;
  logic [IP_WIDTH:0]           tree_in;
  logic [RES_WIDTH-1:0]        tree_out;
  logic                        resp_valid;
  logic [1:0]                  resp_id;
  logic [RES_WIDTH-1:0]        resp_rule_set;
  logic                        resp_ready;
  logic                        busy;
`ifdef DIP_ARB_STATS_EN
  logic [15:0]                 stat_lookups;
  logic [15:0]                 stat_stall;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  dip_lookup_arbiter #(
    .NUM_REQ(NUM_REQ), .IP_WIDTH(IP_WIDTH), .RES_WIDTH(RES_WIDTH), .LAT(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ip(req_ip),
    .req_ready(req_ready),
    .tree_in(tree_in),
    .tree_out(tree_out),
    .resp_valid(resp_valid),
    .resp_id(resp_id),
    .resp_rule_set(resp_rule_set),
    .resp_ready(resp_ready),
    .busy(busy)
`ifdef DIP_ARB_STATS_EN
    ,
    .stat_lookups(stat_lookups),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Reference rule table: two fixed entries from the test plan, a swap-and-xor pattern elsewhere.
  function automatic logic [31:0] ruleOf(input logic [31:0] ip);
    if (ip == 32'hD500000A)      return 32'h00008AEF;
    else if (ip == 32'h0A000001) return 32'h00000000;
    else                         return {ip[15:0], ip[31:16]} ^ 32'h88888888;
  endfunction

  // Behavioural match tree: LAT register stages after tree_in, never reset.
  logic [RES_WIDTH-1:0] treePipe [LAT];
  always @(posedge clk) begin
    treePipe[0] <= tree_in[IP_WIDTH] ? ruleOf(tree_in[IP_WIDTH-1:0]) : 32'h0;
    for (int j = 1; j < LAT; j++) treePipe[j] <= treePipe[j-1];
  end
  assign tree_out = treePipe[LAT-1];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int who, input logic [31:0] ip);
    req_valid[who] = 1'b1;
    req_ip[(NUM_REQ-1-who)*IP_WIDTH +: IP_WIDTH] = ip;
  endtask

  task automatic waitIdle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    checkOutput("idleWithinBound", 64'(n < bound), 64'd1);
  endtask

  // One lookup from requester 'who', checking issue timing and the exact response cycle.
  task automatic doSingle(input int who, input logic [31:0] ip, input logic [31:0] expRule);
    req_valid = '0;
    applyStimulus(who, ip);
    #1;
    checkOutput($sformatf("singleGrant%0d", who), 64'(req_ready), 64'(4'b0001 << who));
    tick();
    req_valid = '0;
    #1;
    checkOutput("singleTreeIn", 64'(tree_in), 64'({1'b1, ip}));
    repeat (6) tick();
    #1;
    checkOutput("singleNotEarly", 64'(resp_valid), 64'd0);
    tick();
    #1;
    checkOutput("singleRespValid", 64'(resp_valid), 64'd1);
    checkOutput("singleRespId", 64'(resp_id), 64'(who));
    checkOutput("singleRespRule", 64'(resp_rule_set), 64'(expRule));
    tick();
    #1;
    checkOutput("singleDrained", 64'({resp_valid, busy}), 64'd0);
  endtask

  initial begin
    int grants;
    req_valid  = '0;
    req_ip     = '0;
    resp_ready = 1'b0;
    #3;
    checkOutput("resetOutputs",
                64'({req_ready, tree_in[IP_WIDTH], tree_in[IP_WIDTH-1:0] != 32'h0, resp_valid, resp_id, busy}),
                64'd0);
    checkOutput("resetRule", 64'(resp_rule_set), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Round robin: all requesters valid, grants must rotate 0,1,2,3 from reset pointer
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 32'hC0A80000 + 32'(i));
      #1;
      checkOutput($sformatf("rrGrant%0d", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
      tick();
    end
    req_valid = '0;
    for (int r = 0; r < 8; r++) begin
      #1;
      checkOutput($sformatf("rrRespValid%0d", r), 64'(resp_valid), 64'd1);
      checkOutput($sformatf("rrRespId%0d", r), 64'(resp_id), 64'(r % 4));
      checkOutput($sformatf("rrRespRule%0d", r), 64'(resp_rule_set), 64'(ruleOf(32'hC0A80000 + 32'(r % 4))));
      tick();
    end
    #1;
    checkOutput("rrDrained", 64'({resp_valid, busy}), 64'd0);

    doSingle(2, 32'hD500000A, 32'h00008AEF);
    doSingle(1, 32'h0A000001, 32'h00000000);

    // Credit back-pressure with the consumer stalled
    resp_ready = 1'b0;
    grants = 0;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 32'h0B000000 + 32'(i));
      #1;
      grants += $countones(req_ready);
      tick();
    end
    checkOutput("bpGrantCount", 64'(grants), 64'd8);
    #1;
    checkOutput("bpStalled", 64'(req_ready), 64'd0);
    resp_ready = 1'b1;
    #1;
    checkOutput("bpFullHead", 64'(resp_valid), 64'd1);
    checkOutput("bpPopSameCycle", 64'(req_ready), 64'd0);
    tick();
    resp_ready = 1'b0;
    #1;
    checkOutput("bpOneGrant", 64'($countones(req_ready)), 64'd1);
    tick();
    #1;
    checkOutput("bpStalledAgain", 64'(req_ready), 64'd0);
    req_valid  = '0;
    resp_ready = 1'b1;
    waitIdle(60);

    // Asynchronous reset with lookups in flight
    for (int i = 0; i < 3; i++) begin
      req_valid = '0;
      applyStimulus(i, 32'h0C000000 + 32'(i));
      tick();
    end
    req_valid = '0;
    applyStimulus(0, 32'h0C0000FF);
    tick();
    #1;
    checkOutput("midBusy", 64'(busy), 64'd1);
    checkOutput("midTreeIn", 64'(tree_in), 64'({1'b1, 32'h0C0000FF}));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncResetOutputs",
                64'({req_ready, tree_in[IP_WIDTH], tree_in[IP_WIDTH-1:0] != 32'h0, resp_valid, resp_id, busy}),
                64'd0);
    checkOutput("asyncResetRule", 64'(resp_rule_set), 64'd0);
    tick();
    req_valid = '0;
    reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      checkOutput($sformatf("postResetQuiet%0d", n), 64'(resp_valid), 64'd0);
      tick();
    end
    checkOutput("postResetIdle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
